// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-side arbiter and its
// round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int BURST_MAX_DEFAULT = 4;

    // Index width for n producers; a single producer still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Beat counter must hold 0..burst_max inclusive.
    function automatic int beat_width(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side request/data bus plus the FIFO write port, shared by the
// producers/FIFO (master) and the arbiter (slave).
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_en_write;
    logic [DATA_WIDTH-1:0]         fifo_data_in;

    modport master (
        output req, wdata, fifo_full,
        input  gnt, fifo_en_write, fifo_data_in
    );

    modport slave (
        input  req, wdata, fifo_full,
        output gnt, fifo_en_write, fifo_data_in
    );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo NUM_REQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic [IDX_W-1:0] cand;

    // NOTE: every output and temporary gets a default before the loop, so no
    // path through this block can leave a value held (no latch inferred).
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Walk offsets from far to near so the nearest requester wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port between NUM_REQ
// producers, with bounded bursts and full back-pressure.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = BURST_MAX_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    fifo_write_arbiter_if.slave           bus,
    output logic                          busy,
    output logic [idx_width(NUM_REQ)-1:0] owner
);
    localparam int                IDX_W     = idx_width(NUM_REQ);
    localparam int                BEAT_W    = beat_width(BURST_MAX);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_MAX - 1);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [BEAT_W-1:0] beats_q;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  next_ptr;
    logic              owner_req;
    logic              accept;
    logic              release_now;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    assign owner_req   = bus.req[owner_q];
    // A full FIFO defers the word, so a full stall on the last beat never releases.
    assign accept      = (state_q == GRANT) && owner_req && !bus.fifo_full && !reset;
    assign release_now = (accept && (beats_q == LAST_BEAT)) || !owner_req;
    assign next_ptr    = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

    assign busy  = (state_q == GRANT);
    assign owner = owner_q;

    always_comb begin
        bus.gnt           = '0;
        bus.fifo_en_write = 1'b0;
        bus.fifo_data_in  = '0;
        if (accept) begin
            bus.gnt[owner_q]  = 1'b1;
            bus.fifo_en_write = 1'b1;
            bus.fifo_data_in  = bus.wdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beats_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        owner_q <= pick_idx;
                        beats_q <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        beats_q <= beats_q + BEAT_W'(1);
                    end
                    if (release_now) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
